// File: rtl/i2s_rx_capture_if.sv
// i2s_rx_capture_if: write-only port into the SDRAM arbiter.
// The arbiter answers each held request with a one-cycle sdram_ac.
interface i2s_rx_capture_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 16
);
    logic              sdram_wr;
    logic [ADDR_W-1:0] sdram_addr;
    logic [DATA_W-1:0] sdram_data;
    logic              sdram_ac;

    modport master (
        output sdram_wr,
        output sdram_addr,
        output sdram_data,
        input  sdram_ac
    );

    modport slave (
        input  sdram_wr,
        input  sdram_addr,
        input  sdram_data,
        output sdram_ac
    );
endinterface

// File: rtl/i2s_rx_capture.sv
// i2s_rx_capture: I2S ADC deserialiser, sample FIFO and SDRAM writer.
// Optional I2S_RX_PEAK_EN adds a peak-magnitude output.
module i2s_rx_capture #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 25
) (
    input  logic              Clk50,
    input  logic              reset,
    input  logic              enable,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_words,
    input  logic              LRClk,
    input  logic              SClk,
    input  logic              Din,
    i2s_rx_capture_if.master  sdram,
    output logic              busy,
    output logic              done,
    output logic              overflow
`ifdef I2S_RX_PEAK_EN
    ,
    output logic [DATA_W-2:0] peak
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_W);
    localparam logic [PTR_W:0]    PTR_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_CAPTURE, S_DRAIN, S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [1:0] lr_s_q, lr_s_d;
    logic [1:0] sck_s_q, sck_s_d;
    logic [1:0] din_s_q, din_s_d;
    logic       sck_h_q, sck_h_d;
    logic       lr_prev_q, lr_prev_d;
    logic       en_prev_q, en_prev_d;

    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-2:0] shift_q, shift_d;

    logic [ADDR_W-1:0] num_q, num_d;
    logic [ADDR_W-1:0] words_q, words_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ovf_q, ovf_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W:0]    wptr_q, wptr_d;
    logic [PTR_W:0]    rptr_q, rptr_d;

    logic              lr, din, sck_rise, lr_edge, left_start;
    logic              word_done, en_rise;
    logic [DATA_W-1:0] word;
    logic              empty, full, pop, push_req, accept;

    assign lr         = lr_s_q[1];
    assign din        = din_s_q[1];
    assign sck_rise   = sck_s_q[1] & ~sck_h_q;
    assign lr_edge    = sck_rise & (lr != lr_prev_q);
    assign left_start = lr_edge & ~lr;
    assign word_done  = sck_rise & ~lr_edge & (bit_cnt_q == CNT_LAST);
    assign word       = {shift_q, din};
    assign en_rise    = enable & ~en_prev_q;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                   (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
    assign pop   = wr_q & sdram.sdram_ac;

    assign push_req = (state_q == S_CAPTURE) & word_done &
                      (words_q < num_q);
    // Pop frees a slot in the same edge, so a full FIFO still accepts.
    assign accept   = push_req & (~full | pop);

`ifdef I2S_RX_PEAK_EN
    localparam logic [DATA_W-2:0] MAG_ONE = 1;
    logic [DATA_W-2:0] peak_q, peak_d, mag;

    always_comb begin
        mag = word[DATA_W-2:0];
        if (word[DATA_W-1]) begin
            if (word[DATA_W-2:0] == '0) mag = '1;
            else mag = ~word[DATA_W-2:0] + MAG_ONE;
        end
        peak_d = peak_q;
        if (state_q == S_IDLE && en_rise) peak_d = '0;
        else if (accept && mag > peak_q) peak_d = mag;
    end

    always_ff @(posedge Clk50 or posedge reset) begin
        if (reset) peak_q <= '0;
        else       peak_q <= peak_d;
    end

    assign peak = peak_q;
`endif

    always_comb begin
        lr_s_d    = {lr_s_q[0], LRClk};
        sck_s_d   = {sck_s_q[0], SClk};
        din_s_d   = {din_s_q[0], Din};
        sck_h_d   = sck_s_q[1];
        en_prev_d = enable;
        lr_prev_d = lr_prev_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        state_d   = state_q;
        num_d     = num_q;
        words_d   = words_q;
        addr_d    = addr_q;
        ovf_d     = ovf_q;
        wr_d      = wr_q;
        data_d    = data_q;
        mem_d     = mem_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;

        // First rise of a new slot carries the old slot's last bit.
        if (sck_rise) begin
            lr_prev_d = lr;
            if (lr != lr_prev_q) begin
                bit_cnt_d = '0;
            end else if (bit_cnt_q < CNT_FULL) begin
                bit_cnt_d = bit_cnt_q + CNT_ONE;
                shift_d   = {shift_q[DATA_W-3:0], din};
            end
        end

        if (accept) begin
            mem_d[wptr_q[PTR_W-1:0]] = word;
            wptr_d  = wptr_q + PTR_ONE;
            words_d = words_q + ADDR_ONE;
        end else if (push_req) begin
            ovf_d = 1'b1;
        end

        if (pop) begin
            wr_d   = 1'b0;
            rptr_d = rptr_q + PTR_ONE;
            addr_d = addr_q + ADDR_ONE;
        end else if (!wr_q && !empty) begin
            wr_d   = 1'b1;
            data_d = mem_q[rptr_q[PTR_W-1:0]];
        end

        unique case (state_q)
            S_IDLE: begin
                if (en_rise) begin
                    num_d   = num_words;
                    addr_d  = base_addr;
                    words_d = '0;
                    ovf_d   = 1'b0;
                    state_d = (num_words == '0) ? S_DONE : S_ARM;
                end
            end
            S_ARM: begin
                if (!enable)         state_d = S_DONE;
                else if (left_start) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (words_q == num_q || !enable) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (empty && !wr_q) state_d = S_DONE;
            end
            S_DONE: begin
                if (!enable) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk50 or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            lr_s_q    <= '0;
            sck_s_q   <= '0;
            din_s_q   <= '0;
            sck_h_q   <= 1'b0;
            en_prev_q <= 1'b0;
            lr_prev_q <= 1'b0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            num_q     <= '0;
            words_q   <= '0;
            addr_q    <= '0;
            ovf_q     <= 1'b0;
            wr_q      <= 1'b0;
            data_q    <= '0;
            mem_q     <= '{default: '0};
            wptr_q    <= '0;
            rptr_q    <= '0;
        end else begin
            state_q   <= state_d;
            lr_s_q    <= lr_s_d;
            sck_s_q   <= sck_s_d;
            din_s_q   <= din_s_d;
            sck_h_q   <= sck_h_d;
            en_prev_q <= en_prev_d;
            lr_prev_q <= lr_prev_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            num_q     <= num_d;
            words_q   <= words_d;
            addr_q    <= addr_d;
            ovf_q     <= ovf_d;
            wr_q      <= wr_d;
            data_q    <= data_d;
            mem_q     <= mem_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
        end
    end

    assign sdram.sdram_wr   = wr_q;
    assign sdram.sdram_addr = addr_q;
    assign sdram.sdram_data = data_q;
    assign busy     = (state_q == S_ARM) || (state_q == S_CAPTURE) ||
                      (state_q == S_DRAIN);
    assign done     = (state_q == S_DONE);
    assign overflow = ovf_q;
endmodule
